// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, FSM state type and command record for the PWM channel.
package pwm_pkg;
    localparam int CNT_W_DEF    = 8;
    localparam int PRE_W_DEF    = 8;
    localparam int DEADTIME_DEF = 2;

    typedef enum logic {IDLE, RUN} pwm_state_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] duty;
        logic [CNT_W_DEF-1:0] period;
    } pwm_cmd_t;
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: issues a tick every (prescale+1) CLK cycles while not cleared.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);
    logic [PRE_W-1:0] cnt_q, cnt_d;

    // A live prescale below the current count lets the count roll over at PRE_W bits.
    always_comb begin
        tick  = !clr && (cnt_q == prescale);
        cnt_d = (clr || tick) ? '0 : cnt_q + PRE_W'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pwm_channel.sv
// pwm_channel: single-channel PWM with shadowed duty/period commands applied at period wrap.
// Define PWM_COMPLEMENT_EN to add the dead-time separated complementary output pwm_out_n.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRE_W = PRE_W_DEF
`ifdef PWM_COMPLEMENT_EN
    ,
    parameter int DEADTIME = DEADTIME_DEF
`endif
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic [PRE_W-1:0] prescale,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_duty,
    input  logic [CNT_W-1:0] cmd_period,
    output logic             pwm_out,
`ifdef PWM_COMPLEMENT_EN
    output logic             pwm_out_n,
`endif
    output logic             period_done,
    output logic             pending
);
    typedef struct packed {
        logic [CNT_W-1:0] duty;
        logic [CNT_W-1:0] period;
    } cmd_t;

    pwm_state_t       state_q, state_d;
    cmd_t             shadow_q, shadow_d, active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d, pwm_q, pwm_d, done_q, done_d;
    logic             run, tick, wrap, accept, apply, raw;

    pwm_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .CLK      (CLK),
        .nRST     (nRST),
        .clr      (!run),
        .prescale (prescale),
        .tick     (tick)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb state_d = en ? RUN : IDLE;

    always_comb run = (state_q == RUN) && en;

    // Output gating follows the next state so a fresh enable shows counter 0 immediately.
    always_comb begin
        wrap      = tick && (cnt_q == active_q.period);
        accept    = cmd_valid && !pending_q;
        apply     = pending_q && (!run || wrap);
        cnt_d     = (!run || wrap) ? '0 : tick ? cnt_q + CNT_W'(1) : cnt_q;
        shadow_d  = accept ? {cmd_duty, cmd_period} : shadow_q;
        pending_d = accept || (pending_q && !apply);
        active_d  = apply ? shadow_q : active_q;
        done_d    = wrap;
        raw       = (state_d == RUN) && (cnt_d < active_d.duty);
    end

`ifdef PWM_COMPLEMENT_EN
    localparam logic [CNT_W:0] DT = (CNT_W+1)'(DEADTIME);
    logic [CNT_W:0] cnt_x, duty_x, period_x;
    logic           pwm_n_q, pwm_n_d;

    // Each output rises only DEADTIME ticks after the other has fallen.
    always_comb begin
        cnt_x    = {1'b0, cnt_d};
        duty_x   = {1'b0, active_d.duty};
        period_x = {1'b0, active_d.period};
        pwm_d    = raw && (duty_x > period_x || cnt_x >= DT);
        pwm_n_d  = (state_d == RUN) && !raw && (duty_x == '0 || cnt_x >= duty_x + DT);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) pwm_n_q <= 1'b0;
        else       pwm_n_q <= pwm_n_d;
    end

    assign pwm_out_n = pwm_n_q;
`else
    assign pwm_d = raw;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            pwm_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
            done_q    <= done_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_done = done_q;
    assign pending     = pending_q;
    assign cmd_ready   = !pending_q;
endmodule

// File: tb/tb_pwm_channel.sv
// tb_pwm_channel: table vectors, hand-written corner sequences and a random run against a period-level model.
module tb_pwm_channel;
    localparam int CW = 8;
    localparam int PW = 8;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          en = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic [CW-1:0] cmd_duty = '0;
    logic [CW-1:0] cmd_period = '0;
    logic          cmd_ready, pwm_out, period_done, pending;
    int            total = 0;
    int            bad = 0;

    always #5 CLK = ~CLK;

    pwm_channel #(.CNT_W(CW), .PRE_W(PW)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .en          (en),
        .prescale    (prescale),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_duty    (cmd_duty),
        .cmd_period  (cmd_period),
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .pending     (pending)
    );

    typedef struct {
        int s;
        int d;
        int p;
        int hi;
        int len;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0;
        cmd_valid = 1'b0;
        nRST = 1'b0;
        step();
        step();
        nRST = 1'b1;
        step();
    endtask

    // Enable, send one command, and stop on the sample of the wrap that applies it.
    task automatic start(input int s, input int d, input int p);
        int n;
        prescale = PW'(s);
        en = 1'b1;
        step();
        cmd_valid = 1'b1;
        cmd_duty = CW'(d);
        cmd_period = CW'(p);
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (!(period_done && !pending) && n < 600) begin
            step();
            n++;
        end
        if (n >= 600) check("apply_timeout", 0, 1);
    endtask

    task automatic measure(input int n, output int hi, output int done_at);
        hi = 0;
        done_at = -1;
        for (int i = 0; i < n; i++) begin
            hi += int'(pwm_out);
            if (i > 0 && period_done && done_at < 0) done_at = i;
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   hi, dat, n, pc;
        vecs[0] = '{0, 3, 7, 3, 8};
        vecs[1] = '{3, 2, 3, 8, 16};
        vecs[2] = '{0, 0, 7, 0, 8};
        vecs[3] = '{0, 9, 7, 8, 8};
        vecs[4] = '{1, 2, 5, 4, 12};
        vecs[5] = '{0, 1, 0, 1, 1};
        vecs[6] = '{2, 0, 0, 0, 3};
        vecs[7] = '{1, 200, 4, 10, 10};

        do_reset();
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_done", int'(period_done), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_ready", int'(cmd_ready), 1);

        foreach (vecs[i]) begin
            do_reset();
            start(vecs[i].s, vecs[i].d, vecs[i].p);
            measure(2 * vecs[i].len, hi, dat);
            check($sformatf("vec%0d_high", i), hi, 2 * vecs[i].hi);
            check($sformatf("vec%0d_done_gap", i), dat, vecs[i].len);
        end

        // Mid-period update, with a second command held off while pending.
        do_reset();
        start(0, 3, 7);
        step();
        step();
        cmd_valid = 1'b1;
        cmd_duty = 8'd6;
        cmd_period = 8'd7;
        step();
        check("upd_pending", int'(pending), 1);
        check("upd_ready", int'(cmd_ready), 0);
        cmd_duty = 8'd1;
        cmd_period = 8'd1;
        n = 0;
        pc = 0;
        while (n < 20) begin
            step();
            n++;
            if (period_done) break;
            pc += int'(pending);
        end
        cmd_valid = 1'b0;
        check("upd_wrap_steps", n, 5);
        check("upd_pending_held", pc, 4);
        check("upd_pending_cleared", int'(pending), 0);
        measure(16, hi, dat);
        check("upd_high", hi, 12);
        check("upd_done_gap", dat, 8);

        // Drop enable mid-period, then re-enable for a full period from counter 0.
        do_reset();
        start(0, 3, 7);
        step();
        en = 1'b0;
        step();
        check("dis_pwm", int'(pwm_out), 0);
        check("dis_done", int'(period_done), 0);
        step();
        step();
        check("dis_pwm_hold", int'(pwm_out), 0);
        en = 1'b1;
        step();
        check("reen_first", int'(pwm_out), 1);
        measure(16, hi, dat);
        check("reen_high", hi, 6);
        check("reen_done_gap", dat, 8);

        // Asynchronous reset with a command pending.
        do_reset();
        start(0, 3, 7);
        step();
        cmd_valid = 1'b1;
        cmd_duty = 8'd6;
        step();
        cmd_valid = 1'b0;
        check("arst_pre_pending", int'(pending), 1);
        #2 nRST = 1'b0;
        #1;
        check("arst_pwm", int'(pwm_out), 0);
        check("arst_pending", int'(pending), 0);
        check("arst_ready", int'(cmd_ready), 1);
        check("arst_done", int'(period_done), 0);
        @(negedge CLK);
        nRST = 1'b1;
        step();
        hi = 0;
        pc = 0;
        for (int i = 0; i < 20; i++) begin
            hi += int'(pwm_out);
            pc += int'(pending);
            step();
        end
        check("arst_no_apply", hi, 0);
        check("arst_no_pending", pc, 0);

        // Random commands against a period-level model.
        for (int seg = 0; seg < 3; seg++) begin
            int s, k, len, md, mp, sd, sp;
            bit mpend, acc, wr;
            do_reset();
            s = int'($urandom_range(0, 3));
            prescale = PW'(s);
            en = 1'b1;
            step();
            k = 0;
            md = 0;
            mp = 0;
            len = s + 1;
            mpend = 1'b0;
            sd = 0;
            sp = 0;
            for (int c = 0; c < 700; c++) begin
                if (!cmd_valid && $urandom_range(0, 9) == 0) begin
                    cmd_valid = 1'b1;
                    cmd_duty = CW'($urandom_range(0, 12));
                    cmd_period = CW'($urandom_range(0, 9));
                end
                acc = cmd_valid && !mpend;
                k++;
                wr = (k == len);
                if (wr) begin
                    k = 0;
                    if (mpend) begin
                        md = sd;
                        mp = sp;
                        mpend = 1'b0;
                    end
                    len = (mp + 1) * (s + 1);
                end
                if (acc) begin
                    sd = int'(cmd_duty);
                    sp = int'(cmd_period);
                    mpend = 1'b1;
                end
                step();
                if (acc) cmd_valid = 1'b0;
                check($sformatf("rand_s%0d_c%0d", s, c),
                      int'({pwm_out, period_done, pending, cmd_ready}),
                      int'({(k / (s + 1)) < md, wr, mpend, !mpend}));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
